// File: rtl/txtbuf_arbiter.sv
// Text-page RAM arbiter: the video fetch always wins the single RAM port, the host
// gets idle slots, and a hardware clear fills the page with FILL when the port is free.
module txtbuf_arbiter #(
   parameter logic [15:0] ADDR_LO = 16'h0400,
   parameter logic [15:0] ADDR_HI = 16'h07F7,
   parameter logic [7:0]  FILL    = 8'hA0
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        vid_req,
   input  logic [15:0] vid_adr,
   output logic        vid_valid,
   output logic [7:0]  vid_data,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic        host_we,
   input  logic [15:0] host_adr,
   input  logic [7:0]  host_wdata,
   output logic        host_rvalid,
   output logic [7:0]  host_rdata,
   output logic        host_err,
   input  logic        clr_start,
   output logic        clr_busy,
   output logic [15:0] ram_adr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata
);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t      state_q, state_d;
   logic [16:0] ptr_q, ptr_d;
   logic [15:0] ram_adr_q, ram_adr_d;
   logic        ram_we_q, ram_we_d;
   logic [7:0]  ram_wdata_q, ram_wdata_d;
   logic        vid_p1_q, vid_p1_d;
   logic        vid_oor_p1_q, vid_oor_p1_d;
   logic        vid_valid_q, vid_valid_d;
   logic        vid_oor_q, vid_oor_d;
   logic        host_rd_p1_q, host_rd_p1_d;
   logic        host_rvalid_q, host_rvalid_d;
   logic        host_err_q, host_err_d;

   logic vid_in_rng;
   logic host_in_rng;
   logic host_acc;
   logic clr_done;

   assign vid_in_rng  = (vid_adr >= ADDR_LO) && (vid_adr <= ADDR_HI);
   assign host_in_rng = (host_adr >= ADDR_LO) && (host_adr <= ADDR_HI);
   // clr_start in IDLE takes precedence, so the host must not see ready that cycle
   assign host_ready  = (state_q == ST_IDLE) && !vid_req && !clr_start;
   assign host_acc    = host_valid && host_ready;
   // pointer runs one past ADDR_HI so clr_busy stays up during the last write
   assign clr_done    = (ptr_q > {1'b0, ADDR_HI});

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      ram_adr_d     = ram_adr_q;
      ram_we_d      = 1'b0;
      ram_wdata_d   = ram_wdata_q;
      vid_p1_d      = vid_req;
      vid_oor_p1_d  = vid_req && !vid_in_rng;
      vid_valid_d   = vid_p1_q;
      vid_oor_d     = vid_oor_p1_q;
      host_rd_p1_d  = 1'b0;
      host_rvalid_d = host_rd_p1_q;
      host_err_d    = host_acc && !host_in_rng;

      if (vid_req && vid_in_rng) begin
         ram_adr_d = vid_adr;
      end else if ((state_q == ST_CLEAR) && !clr_done) begin
         ram_adr_d   = ptr_q[15:0];
         ram_we_d    = 1'b1;
         ram_wdata_d = FILL;
         ptr_d       = ptr_q + 17'd1;
      end else if (host_acc && host_in_rng) begin
         ram_adr_d    = host_adr;
         ram_we_d     = host_we;
         host_rd_p1_d = !host_we;
         if (host_we) begin
            ram_wdata_d = host_wdata;
         end
      end

      if ((state_q == ST_CLEAR) && clr_done) begin
         state_d = ST_IDLE;
      end else if ((state_q == ST_IDLE) && clr_start) begin
         state_d = ST_CLEAR;
         ptr_d   = {1'b0, ADDR_LO};
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_CLEAR;
         ptr_q         <= {1'b0, ADDR_LO};
         ram_adr_q     <= ADDR_LO;
         ram_we_q      <= 1'b0;
         ram_wdata_q   <= 8'h00;
         vid_p1_q      <= 1'b0;
         vid_oor_p1_q  <= 1'b0;
         vid_valid_q   <= 1'b0;
         vid_oor_q     <= 1'b0;
         host_rd_p1_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         host_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         ram_adr_q     <= ram_adr_d;
         ram_we_q      <= ram_we_d;
         ram_wdata_q   <= ram_wdata_d;
         vid_p1_q      <= vid_p1_d;
         vid_oor_p1_q  <= vid_oor_p1_d;
         vid_valid_q   <= vid_valid_d;
         vid_oor_q     <= vid_oor_d;
         host_rd_p1_q  <= host_rd_p1_d;
         host_rvalid_q <= host_rvalid_d;
         host_err_q    <= host_err_d;
      end
   end

   // return data is taken straight off the RAM in the cycle its strobe is high
   assign vid_valid   = vid_valid_q;
   assign vid_data    = vid_valid_q ? (vid_oor_q ? FILL : ram_rdata) : 8'h00;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rvalid_q ? ram_rdata : 8'h00;
   assign host_err    = host_err_q;
   assign clr_busy    = (state_q == ST_CLEAR);
   assign ram_adr     = ram_adr_q;
   assign ram_we      = ram_we_q;
   assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_txtbuf_arbiter.sv
// Directed bench for txtbuf_arbiter: a behavioural single-port RAM, a table of
// host/video accesses with hand-computed results, and sequences for clear and reset.
module tb_txtbuf_arbiter;

   localparam logic [15:0] LO = 16'h0400;
   localparam logic [15:0] HI = 16'h07F7;
   localparam logic [7:0]  FL = 8'hA0;

   logic        CLOCK_50;
   logic        reset;
   logic        vid_req;
   logic [15:0] vid_adr;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        host_valid;
   logic        host_ready;
   logic        host_we;
   logic [15:0] host_adr;
   logic [7:0]  host_wdata;
   logic        host_rvalid;
   logic [7:0]  host_rdata;
   logic        host_err;
   logic        clr_start;
   logic        clr_busy;
   logic [15:0] ram_adr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   logic [7:0]  mem [0:65535];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        is_vid;
      logic        we;
      logic [15:0] adr;
      logic [7:0]  wdata;
      logic        exp_err;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [15];
   vec_t post_clr;

   txtbuf_arbiter dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .vid_req    (vid_req),
      .vid_adr    (vid_adr),
      .vid_valid  (vid_valid),
      .vid_data   (vid_data),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_we    (host_we),
      .host_adr   (host_adr),
      .host_wdata (host_wdata),
      .host_rvalid(host_rvalid),
      .host_rdata (host_rdata),
      .host_err   (host_err),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
      .ram_adr    (ram_adr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // external text RAM: synchronous write, one-cycle read latency
   always @(posedge CLOCK_50) begin
      if (ram_we) mem[ram_adr] <= ram_wdata;
      ram_rdata <= mem[ram_adr];
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      if (v.is_vid) begin
         vid_req = 1'b1;
         vid_adr = v.adr;
         step();
         vid_req = 1'b0;
         chk("vid_ram_we", 32'(ram_we), 32'd0);
         if (!v.exp_err) chk("vid_ram_adr", 32'(ram_adr), 32'(v.adr));
         step();
         chk("vid_valid_k2", 32'(vid_valid), 32'd1);
         chk("vid_data_k2", 32'(vid_data), 32'(v.exp_data));
         step();
         chk("vid_valid_k3", 32'(vid_valid), 32'd0);
         $display("vec %0d: vid adr=%h data=%h", idx, v.adr, v.exp_data);
      end else begin
         host_valid = 1'b1;
         host_we    = v.we;
         host_adr   = v.adr;
         host_wdata = v.wdata;
         #1;
         chk("host_ready_idle", 32'(host_ready), 32'd1);
         step();
         host_valid = 1'b0;
         chk("host_err_k1", 32'(host_err), 32'(v.exp_err));
         if (v.exp_err) begin
            chk("host_err_no_we", 32'(ram_we), 32'd0);
         end else begin
            chk("host_ram_we", 32'(ram_we), 32'(v.we));
            chk("host_ram_adr", 32'(ram_adr), 32'(v.adr));
            if (v.we) chk("host_ram_wdata", 32'(ram_wdata), 32'(v.wdata));
         end
         step();
         chk("host_rvalid_k2", 32'(host_rvalid), 32'(!v.we && !v.exp_err));
         chk("host_err_k2", 32'(host_err), 32'd0);
         if (!v.we && !v.exp_err) chk("host_rdata_k2", 32'(host_rdata), 32'(v.exp_data));
         $display("vec %0d: host we=%0d adr=%h wdata=%h err=%0d rdata=%h",
                  idx, v.we, v.adr, v.wdata, v.exp_err, v.exp_data);
      end
   endtask

   // Follows a full clear, checking the write order, the video slots it yields
   // and the drop of clr_busy one cycle after the ADDR_HI write.
   task automatic run_clear(input int vid_period, input int pulse_at);
      logic [16:0] exp;
      logic [15:0] a1;
      logic        p1, p2, done;
      int          w, cyc;
      exp = {1'b0, LO};
      a1 = 16'h0;
      p1 = 1'b0;
      p2 = 1'b0;
      done = 1'b0;
      w = 0;
      cyc = 0;
      while (!done && cyc < 4000) begin
         if (p2) begin
            chk("clr_vid_valid", 32'(vid_valid), 32'd1);
            chk("clr_vid_data", 32'(vid_data), 32'(FL));
         end
         if (p1) begin
            chk("clr_vid_owns_ram", 32'(ram_we), 32'd0);
            chk("clr_vid_adr", 32'(ram_adr), 32'(a1));
         end
         if (ram_we) begin
            if (w == 0) chk("clr_first_cycle", 32'(cyc), 32'd1);
            chk("clr_adr", 32'(ram_adr), 32'(exp[15:0]));
            chk("clr_wdata", 32'(ram_wdata), 32'(FL));
            chk("clr_busy_during", 32'(clr_busy), 32'd1);
            exp = exp + 17'd1;
            w++;
            if (exp > {1'b0, HI}) done = 1'b1;
         end
         p2 = p1;
         clr_start = (cyc == pulse_at);
         vid_req = (vid_period != 0) && (w >= 2) && (w < 1000) && (cyc % vid_period == 0);
         vid_adr = LO + 16'(w / 2);
         p1 = vid_req;
         a1 = vid_adr;
         step();
         cyc++;
      end
      clr_start = 1'b0;
      vid_req = 1'b0;
      if (!done) chk("clr_timeout", 32'd0, 32'd1);
      chk("clr_write_count", 32'(w), 32'd1016);
      chk("clr_busy_drop", 32'(clr_busy), 32'd0);
      chk("clr_idle_ready", 32'(host_ready), 32'd1);
      $display("clear: %0d writes in %0d cycles, vid_period=%0d", w, cyc, vid_period);
   endtask

   logic [15:0] bb_adr [4];
   logic [7:0]  bb_exp [4];
   logic        bb_rng [4];

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      vecs[0]  = '{1'b0, 1'b1, 16'h0410, 8'h48, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 16'h0410, 8'h00, 1'b0, 8'h48};
      vecs[2]  = '{1'b0, 1'b1, 16'h07F7, 8'h5A, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 16'h07F7, 8'h00, 1'b0, 8'h5A};
      vecs[4]  = '{1'b0, 1'b0, 16'h0400, 8'h00, 1'b0, 8'hA0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0800, 8'h00, 1'b1, 8'h00};
      vecs[6]  = '{1'b0, 1'b1, 16'h03FF, 8'h77, 1'b1, 8'h00};
      vecs[7]  = '{1'b0, 1'b0, 16'h07F8, 8'h00, 1'b1, 8'h00};
      vecs[8]  = '{1'b0, 1'b1, 16'h0400, 8'h11, 1'b0, 8'h00};
      vecs[9]  = '{1'b0, 1'b0, 16'h0400, 8'h00, 1'b0, 8'h11};
      vecs[10] = '{1'b1, 1'b0, 16'h0410, 8'h00, 1'b0, 8'h48};
      vecs[11] = '{1'b1, 1'b0, 16'h03FF, 8'h00, 1'b1, 8'hA0};
      vecs[12] = '{1'b1, 1'b0, 16'h0800, 8'h00, 1'b1, 8'hA0};
      vecs[13] = '{1'b1, 1'b0, 16'h07F7, 8'h00, 1'b0, 8'h5A};
      vecs[14] = '{1'b0, 1'b0, 16'h0401, 8'h00, 1'b0, 8'hA0};
      post_clr = '{1'b0, 1'b0, 16'h0410, 8'h00, 1'b0, 8'hA0};

      bb_adr[0] = 16'h0410; bb_exp[0] = 8'h48; bb_rng[0] = 1'b1;
      bb_adr[1] = 16'h07F7; bb_exp[1] = 8'h5A; bb_rng[1] = 1'b1;
      bb_adr[2] = 16'h0400; bb_exp[2] = 8'h11; bb_rng[2] = 1'b1;
      bb_adr[3] = 16'h03FF; bb_exp[3] = 8'hA0; bb_rng[3] = 1'b0;

      reset = 1'b0;
      vid_req = 1'b1;
      vid_adr = 16'h0500;
      host_valid = 1'b0;
      host_we = 1'b0;
      host_adr = 16'h0;
      host_wdata = 8'h0;
      clr_start = 1'b0;

      // reset held with video traffic present: everything stays quiet
      step();
      step();
      chk("rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("rst_vid_data", 32'(vid_data), 32'd0);
      chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);
      chk("rst_host_err", 32'(host_err), 32'd0);
      chk("rst_host_ready", 32'(host_ready), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_ram_adr", 32'(ram_adr), 32'(LO));
      chk("rst_clr_busy", 32'(clr_busy), 32'd1);
      vid_req = 1'b0;
      reset = 1'b1;
      run_clear(0, -1);

      for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

      // back-to-back video fetches at full rate
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) begin
            chk("bb_vid_valid", 32'(vid_valid), 32'd1);
            chk("bb_vid_data", 32'(vid_data), 32'(bb_exp[i-2]));
         end
         if (i >= 1 && i <= 4) begin
            if (bb_rng[i-1]) chk("bb_ram_adr", 32'(ram_adr), 32'(bb_adr[i-1]));
            chk("bb_ram_we", 32'(ram_we), 32'd0);
         end
         vid_req = (i < 4);
         if (i < 4) vid_adr = bb_adr[i];
         step();
      end
      chk("bb_vid_idle", 32'(vid_valid), 32'd0);
      $display("burst: 4 back-to-back video fetches");

      // host and video in the same cycle: video first, host accepted next cycle
      host_valid = 1'b1;
      host_we = 1'b0;
      host_adr = 16'h0410;
      vid_req = 1'b1;
      vid_adr = 16'h07F7;
      #1;
      chk("cont_ready_low", 32'(host_ready), 32'd0);
      step();
      vid_req = 1'b0;
      #1;
      chk("cont_ready_high", 32'(host_ready), 32'd1);
      chk("cont_vid_adr", 32'(ram_adr), 32'h07F7);
      chk("cont_vid_we", 32'(ram_we), 32'd0);
      step();
      host_valid = 1'b0;
      chk("cont_host_adr", 32'(ram_adr), 32'h0410);
      chk("cont_vid_valid", 32'(vid_valid), 32'd1);
      chk("cont_vid_data", 32'(vid_data), 32'h5A);
      step();
      chk("cont_host_rvalid", 32'(host_rvalid), 32'd1);
      chk("cont_host_rdata", 32'(host_rdata), 32'h48);
      chk("cont_vid_done", 32'(vid_valid), 32'd0);
      $display("contention: video 07F7 then host read 0410");

      // clr_start with a host write: clear wins, write never happens
      clr_start = 1'b1;
      host_valid = 1'b1;
      host_we = 1'b1;
      host_adr = 16'h0410;
      host_wdata = 8'h99;
      #1;
      chk("clrst_ready_low", 32'(host_ready), 32'd0);
      step();
      clr_start = 1'b0;
      host_valid = 1'b0;
      chk("clrst_busy", 32'(clr_busy), 32'd1);
      chk("clrst_no_host_we", 32'(ram_we), 32'd0);
      run_clear(3, 200);
      apply_vec(post_clr, 15);

      // reset while two host reads are in flight
      host_valid = 1'b1;
      host_we = 1'b0;
      host_adr = 16'h0410;
      step();
      step();
      chk("mid_rvalid_before", 32'(host_rvalid), 32'd1);
      #2;
      reset = 1'b0;
      host_valid = 1'b0;
      #1;
      chk("mid_rvalid_async", 32'(host_rvalid), 32'd0);
      chk("mid_ram_adr", 32'(ram_adr), 32'(LO));
      chk("mid_clr_busy", 32'(clr_busy), 32'd1);
      step();
      chk("mid_rvalid_held", 32'(host_rvalid), 32'd0);
      reset = 1'b1;
      run_clear(0, -1);
      $display("reset mid-flight: clear restarted");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/txtbuf_arbiter.md
TXTBUF_ARBITER -- requirements
Module: txtbuf_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LO, default 16'h0400, lowest text-page address.
REQ-002 SHALL have parameter ADDR_HI, default 16'h07F7, highest text-page address.
REQ-003 SHALL have parameter FILL, default 8'hA0, blank character written by clear.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports vid_req in 1 and vid_adr in 16: display fetch request pulse and its address.
REQ-007 SHALL have ports vid_valid out 1 and vid_data out 8: fetched character and its strobe.
REQ-008 SHALL have ports host_valid in 1, host_ready out 1, host_we in 1, host_adr in 16, host_wdata in 8: host access request.
REQ-009 SHALL have ports host_rvalid out 1, host_rdata out 8, host_err out 1: host read return and range-error pulse.
REQ-010 SHALL have ports clr_start in 1 and clr_busy out 1: clear request and clear-in-progress flag.
REQ-011 SHALL have ports ram_adr out 16, ram_we out 1, ram_wdata out 8, ram_rdata in 8: single-port text RAM, read data valid one cycle after address.

Function
REQ-012 SHALL issue at most one RAM access per cycle; ram_adr/ram_we/ram_wdata registered.
REQ-013 SHALL implement states CLEAR and IDLE; CLEAR entered from reset or clr_start in IDLE.
REQ-014 SHALL give video absolute priority: vid_req high in cycle k issues a RAM read in cycle k+1 in any state.
REQ-015 SHALL assert vid_valid for exactly one cycle at k+2 with vid_data = ram_rdata; back-to-back vid_req every cycle sustained at full rate.
REQ-016 SHALL, for vid_adr outside [ADDR_LO, ADDR_HI], issue no RAM access and still return vid_data = FILL with vid_valid at k+2.
REQ-017 SHALL drive host_ready = 1 only in IDLE with vid_req low in the same cycle (combinational on vid_req).
REQ-018 SHALL complete a host transfer when host_valid && host_ready; host_valid held with stable fields until accepted.
REQ-019 SHALL, for accepted host write in range, drive ram_we = 1, ram_adr = host_adr, ram_wdata = host_wdata in k+1.
REQ-020 SHALL, for accepted host read in range, assert host_rvalid for one cycle at k+2 with host_rdata = ram_rdata.
REQ-021 SHALL, for accepted host access out of range, issue no RAM access, pulse host_err at k+1, never assert host_rvalid.
REQ-022 SHALL in CLEAR write FILL to addresses ADDR_LO..ADDR_HI ascending, one per free cycle (1016 writes at defaults).
REQ-023 SHALL pause the clear pointer (no skip, no repeat) on any cycle video takes the RAM.
REQ-024 SHALL hold clr_busy = 1 throughout CLEAR; return to IDLE and drop clr_busy the cycle after the ADDR_HI write.
REQ-025 SHALL ignore clr_start while in CLEAR; clr_start and host_valid together in IDLE: clear wins, host not accepted.
REQ-026 SHALL keep vid and host return pipelines tagged separately; a reset mid-flight discards all pending returns.

Reset
REQ-027 SHALL while reset low force vid_valid, host_rvalid, host_err, ram_we, host_ready = 0; vid_data, host_rdata, ram_wdata = 0; ram_adr = ADDR_LO.
REQ-028 SHALL while reset low hold state CLEAR with pointer ADDR_LO and clr_busy = 1.
REQ-029 SHALL begin clear writes on the first rising edge after reset deasserts.

Verification
REQ-030 Release reset, no traffic -> 1016 writes of 8'hA0 to 16'h0400..16'h07F7 in order, clr_busy falls after the 1016th.
REQ-031 During clear, vid_req every 3rd cycle -> every vid read returns at k+2, clear still writes each address exactly once.
REQ-032 IDLE, host write 16'h0410 = "H" then read 16'h0410 -> host_rvalid at k+2 with host_rdata = 8'h48.
REQ-033 IDLE, host_valid and vid_req same cycle -> host_ready = 0, video read issued, host accepted next cycle without vid_req.
REQ-034 Host read 16'h0800 -> host_err pulse at k+1, no ram access, no host_rvalid; vid_adr 16'h03FF -> vid_data = 8'hA0.
REQ-035 Assert reset during back-to-back host reads -> no host_rvalid after reset, clear restarts from 16'h0400.
